// File: rtl/path_tracer_pkg.sv
// path_tracer_pkg: shared sizes and FSM encoding for the
// Bellman-Ford path tracer (node width, stack depth, states).
package path_tracer_pkg;

  localparam int NODE_W    = 5;
  localparam int MAX_NODES = 2**NODE_W;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_DEST,
    READ,
    CHECK,
    EMIT,
    FINISH,
    FAIL
  } state_e;

endpackage

// File: rtl/path_tracer_stack.sv
// path_stack: synchronous LIFO holding the traced path.
// Ports: clk, reset (async low), clear/push/pop, din; top, count, empty.
module path_stack #(
  parameter int W     = 5,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic [W:0]   count,
  output logic         empty
);
  import path_tracer_pkg::*;

  localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [W:0]   cnt_q;
  logic [W:0]   top_idx;
  logic         can_push;

  assign can_push = push && (cnt_q < DEPTH_C);
  assign top_idx  = cnt_q - (W+1)'(1);
  assign count    = cnt_q;
  assign empty    = (cnt_q == '0);
  assign top      = empty ? '0 : mem[top_idx[W-1:0]];

  // push wins over a simultaneous pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (can_push) begin
      cnt_q <= cnt_q + (W+1)'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - (W+1)'(1);
    end
  end

  // contents survive reset; only the pointer matters
  always_ff @(posedge clk) begin
    if (can_push && !clear) begin
      mem[cnt_q[W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/path_tracer.sv
// path_tracer: walks the predecessor memory from dest back to source,
// then streams the path source-first to the display writer.
// Ports: clk, reset (async low), start/source_addr/dest_addr request;
// pred_rd_addr/pred_data memory read (1-cycle latency);
// node_out/node_valid/node_ready/node_last stream; path_len, busy,
// done (pulse), error (pulse, no path).
module path_tracer #(
  parameter int NODE_W    = path_tracer_pkg::NODE_W,
  parameter int MAX_NODES = 2**NODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NODE_W-1:0] source_addr,
  input  logic [NODE_W-1:0] dest_addr,
  output logic [NODE_W-1:0] pred_rd_addr,
  input  logic [NODE_W-1:0] pred_data,
  output logic [NODE_W-1:0] node_out,
  output logic              node_valid,
  input  logic              node_ready,
  output logic              node_last,
  output logic [NODE_W:0]   path_len,
  output logic              busy,
  output logic              done,
  output logic              error
);
  import path_tracer_pkg::*;

  localparam logic [NODE_W-1:0] HOP_MAX = NODE_W'(MAX_NODES-1);
  localparam logic [NODE_W:0]   ONE_L   = (NODE_W+1)'(1);

  state_e state_q, state_d;

  logic [NODE_W-1:0] src_q, src_d;
  logic [NODE_W-1:0] dst_q, dst_d;
  logic [NODE_W-1:0] cur_q, cur_d;
  logic [NODE_W-1:0] hop_q, hop_d;
  logic [NODE_W:0]   len_q, len_d;

  logic              stk_clr;
  logic              stk_push;
  logic              stk_pop;
  logic [NODE_W-1:0] stk_din;
  logic [NODE_W-1:0] stk_top;
  logic [NODE_W:0]   stk_cnt;
  logic              stk_empty;

  path_stack #(
    .W     (NODE_W),
    .DEPTH (MAX_NODES)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .clear (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (stk_din),
    .top   (stk_top),
    .count (stk_cnt),
    .empty (stk_empty)
  );

  assign path_len = len_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cur_q   <= '0;
      hop_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cur_q   <= cur_d;
      hop_q   <= hop_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    cur_d        = cur_q;
    hop_d        = hop_q;
    len_d        = len_q;
    stk_clr      = 1'b0;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_din      = '0;
    pred_rd_addr = '0;
    node_out     = '0;
    node_valid   = 1'b0;
    node_last    = 1'b0;
    busy         = (state_q != IDLE);
    done         = 1'b0;
    error        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = source_addr;
          dst_d   = dest_addr;
          hop_d   = '0;
          len_d   = '0;
          stk_clr = 1'b1;
          state_d = PUSH_DEST;
        end
      end
      PUSH_DEST: begin
        stk_push = 1'b1;
        stk_din  = dst_q;
        cur_d    = dst_q;
        if (dst_q == src_q) begin
          len_d   = ONE_L;
          state_d = EMIT;
        end else begin
          pred_rd_addr = dst_q;
          state_d      = READ;
        end
      end
      READ: begin
        // address held so pred_data is valid in CHECK
        pred_rd_addr = cur_q;
        state_d      = CHECK;
      end
      CHECK: begin
        pred_rd_addr = cur_q;
        if (pred_data == src_q) begin
          stk_push = 1'b1;
          stk_din  = pred_data;
          len_d    = stk_cnt + ONE_L;
          state_d  = EMIT;
        end else if (pred_data == cur_q || hop_q == HOP_MAX) begin
          len_d   = '0;
          state_d = FAIL;
        end else begin
          stk_push     = 1'b1;
          stk_din      = pred_data;
          cur_d        = pred_data;
          hop_d        = hop_q + NODE_W'(1);
          pred_rd_addr = pred_data;
          state_d      = READ;
        end
      end
      EMIT: begin
        node_valid = !stk_empty;
        node_out   = stk_top;
        node_last  = (stk_cnt == ONE_L);
        if (node_ready) begin
          stk_pop = 1'b1;
          if (node_last) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        error   = 1'b1;
        len_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_path_tracer.sv
// tb_path_tracer: randomized and directed checks of path_tracer
// against a queue-based path model and a registered pred memory.
module tb_path_tracer;

  localparam int W = 5;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] source_addr = '0;
  logic [W-1:0] dest_addr = '0;
  logic [W-1:0] pred_rd_addr;
  logic [W-1:0] pred_data = '0;
  logic [W-1:0] node_out;
  logic         node_valid;
  logic         node_ready = 1'b0;
  logic         node_last;
  logic [W:0]   path_len;
  logic         busy;
  logic         done;
  logic         error;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] pmem [N];

  logic [W-1:0] got_nodes [$];
  bit           got_last  [$];
  int n_done, n_err, done_cyc, err_cyc;
  int first_v, acc_last_cyc, unstable, rd_nz;
  bit timed_out;

  logic [W-1:0] exp_path [$];
  bit           exp_ok;
  int           exp_n;

  always #5 clk = ~clk;

  always @(posedge clk) pred_data <= pmem[pred_rd_addr];

  path_tracer #(
    .NODE_W    (W),
    .MAX_NODES (N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .source_addr  (source_addr),
    .dest_addr    (dest_addr),
    .pred_rd_addr (pred_rd_addr),
    .pred_data    (pred_data),
    .node_out     (node_out),
    .node_valid   (node_valid),
    .node_ready   (node_ready),
    .node_last    (node_last),
    .path_len     (path_len),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  function automatic string path_str(input logic [W-1:0] q [$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  function automatic string last_str(input bit q [$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d", q[i])};
    return s;
  endfunction

  function automatic bit rdy_next(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return 1'($urandom % 2);
  endfunction

  // Path by walking predecessors from dest; each lookup is one hop.
  task automatic model(input logic [W-1:0] s, input logic [W-1:0] d);
    logic [W-1:0] cur, p;
    exp_path = {};
    exp_path.push_back(d);
    exp_ok = 1'b0;
    exp_n  = 0;
    if (s == d) begin
      exp_ok = 1'b1;
      return;
    end
    cur = d;
    for (int hops = 0; hops < N; hops++) begin
      p = pmem[cur];
      exp_n++;
      if (p == s) begin
        exp_path.push_front(p);
        exp_ok = 1'b1;
        return;
      end
      if (p == cur || hops == N-1) return;
      exp_path.push_front(p);
      cur = p;
    end
  endtask

  task automatic run_trace(input logic [W-1:0] s, input logic [W-1:0] d,
                           input int mode, input bit poke);
    bit hold, r;
    logic [W-1:0] h_out;
    logic h_last;
    got_nodes = {};
    got_last = {};
    n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
    first_v = -1; acc_last_cyc = -1; unstable = 0; rd_nz = 0;
    timed_out = 1'b1; hold = 1'b0; h_out = '0; h_last = 1'b0;
    @(negedge clk);
    source_addr = s;
    dest_addr = d;
    start = 1'b1;
    node_ready = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (pred_rd_addr != '0) rd_nz++;
      if (hold && (node_out !== h_out || node_last !== h_last ||
                   node_valid !== 1'b1)) unstable++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (error) begin n_err++; err_cyc = cyc; end
      r = rdy_next(mode, cyc);
      node_ready = r;
      hold = node_valid && !r;
      h_out = node_out;
      h_last = node_last;
      if (node_valid) begin
        if (first_v < 0) first_v = cyc;
        if (r) begin
          got_nodes.push_back(node_out);
          got_last.push_back(node_last);
          if (node_last) acc_last_cyc = cyc;
        end
      end
      if (poke && busy && !done && !error) begin
        source_addr = W'($urandom);
        dest_addr = W'($urandom);
        start = 1'($urandom % 2);
      end
      if (done || error) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    node_ready = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) pmem[i] = W'($urandom);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #3;
    tests++;
    if ({node_valid, node_last, node_out, busy, done, error} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%b exp=0",
               {node_valid, node_last, node_out, busy, done, error});
    end
    tests++;
    if ({pred_rd_addr, path_len} !== '0) begin
      fails++;
      $display("FAIL reset_addr_len got=%b exp=0", {pred_rd_addr, path_len});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_chain();
    fill_random();
    pmem[12] = 7;
    pmem[7] = 3;
    model(3, 12);
    run_trace(3, 12, 0, 0);
    tests++;
    if (timed_out) begin fails++; $display("FAIL chain_timeout"); end
    tests++;
    if (path_str(got_nodes) != "3 7 12 ") begin
      fails++;
      $display("FAIL chain_nodes got=%s exp=3 7 12", path_str(got_nodes));
    end
    tests++;
    if (last_str(got_last) != "001") begin
      fails++;
      $display("FAIL chain_last got=%s exp=001", last_str(got_last));
    end
    tests++;
    if (path_len !== 6'd3) begin
      fails++;
      $display("FAIL chain_len got=%0d exp=3", path_len);
    end
    tests++;
    if (done_cyc != acc_last_cyc + 1 || n_done != 1) begin
      fails++;
      $display("FAIL chain_done got=%0d exp=%0d", done_cyc, acc_last_cyc + 1);
    end
    tests++;
    if (first_v != 2 * exp_n + 2) begin
      fails++;
      $display("FAIL chain_latency got=%0d exp=%0d", first_v, 2 * exp_n + 2);
    end
  endtask

  task automatic test_same();
    fill_random();
    pmem[5] = 9;
    run_trace(5, 5, 0, 0);
    tests++;
    if (path_str(got_nodes) != "5 " || last_str(got_last) != "1") begin
      fails++;
      $display("FAIL same_nodes got=%s/%s exp=5/1",
               path_str(got_nodes), last_str(got_last));
    end
    tests++;
    if (path_len !== 6'd1 || n_done != 1) begin
      fails++;
      $display("FAIL same_len got=%0d exp=1", path_len);
    end
    tests++;
    if (rd_nz != 0) begin
      fails++;
      $display("FAIL same_noread got=%0d exp=0", rd_nz);
    end
  endtask

  task automatic test_self_loop();
    fill_random();
    pmem[9] = 9;
    run_trace(2, 9, 2, 0);
    tests++;
    if (n_err != 1 || n_done != 0) begin
      fails++;
      $display("FAIL selfloop_err got=%0d exp=1", n_err);
    end
    tests++;
    if (first_v != -1 || got_nodes.size() != 0) begin
      fails++;
      $display("FAIL selfloop_valid got=%0d exp=-1", first_v);
    end
    tests++;
    if (path_len !== '0) begin
      fails++;
      $display("FAIL selfloop_len got=%0d exp=0", path_len);
    end
    tests++;
    if (err_cyc != 4) begin
      fails++;
      $display("FAIL selfloop_latency got=%0d exp=4", err_cyc);
    end
  endtask

  task automatic test_loop();
    fill_random();
    pmem[4] = 6;
    pmem[6] = 4;
    run_trace(1, 4, 0, 0);
    tests++;
    if (n_err != 1 || got_nodes.size() != 0) begin
      fails++;
      $display("FAIL loop_err got=%0d exp=1", n_err);
    end
    tests++;
    if (err_cyc != 2 * N + 2) begin
      fails++;
      $display("FAIL loop_hops got=%0d exp=%0d", err_cyc, 2 * N + 2);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL loop_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_stall();
    fill_random();
    pmem[12] = 7;
    pmem[7] = 3;
    run_trace(3, 12, 1, 1);
    tests++;
    if (path_str(got_nodes) != "3 7 12 " || n_done != 1) begin
      fails++;
      $display("FAIL stall_nodes got=%s exp=3 7 12", path_str(got_nodes));
    end
    tests++;
    if (unstable != 0) begin
      fails++;
      $display("FAIL stall_hold got=%0d exp=0", unstable);
    end
    tests++;
    if (path_len !== 6'd3) begin
      fails++;
      $display("FAIL stall_len got=%0d exp=3", path_len);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_noqueue got=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_emit();
    bit seen;
    fill_random();
    pmem[12] = 7;
    pmem[7] = 3;
    @(negedge clk);
    source_addr = 3;
    dest_addr = 12;
    start = 1'b1;
    node_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (node_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!seen || node_out !== 5'd3) begin
      fails++;
      $display("FAIL rstemit_first got=%0d exp=3", node_out);
    end
    node_ready = 1'b1;
    @(negedge clk);
    node_ready = 1'b0;
    tests++;
    if (node_out !== 5'd7) begin
      fails++;
      $display("FAIL rstemit_second got=%0d exp=7", node_out);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({node_valid, node_last, node_out, busy, done, error,
         pred_rd_addr, path_len} !== '0) begin
      fails++;
      $display("FAIL rstemit_zero got=%b exp=0",
               {node_valid, node_last, node_out, busy, done, error,
                pred_rd_addr, path_len});
    end
    @(negedge clk);
    reset = 1'b1;
    run_trace(3, 12, 0, 0);
    tests++;
    if (path_str(got_nodes) != "3 7 12 " || n_done != 1 || n_err != 0) begin
      fails++;
      $display("FAIL rstemit_retrace got=%s exp=3 7 12", path_str(got_nodes));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] perm [N];
    logic [W-1:0] s, d, t;
    int len, j, lat;
    string exp_s;
    for (int it = 0; it < 16; it++) begin
      fill_random();
      if (it % 2 == 0) begin
        for (int i = 0; i < N; i++) perm[i] = W'(i);
        for (int i = N - 1; i > 0; i--) begin
          j = $urandom_range(i, 0);
          t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        len = $urandom_range(12, 1);
        for (int i = 1; i < len; i++) pmem[perm[i]] = perm[i-1];
        s = perm[0];
        d = perm[len-1];
      end else begin
        s = W'($urandom);
        d = W'($urandom);
      end
      model(s, d);
      run_trace(s, d, 2, 1'($urandom % 2));
      exp_s = exp_ok ? path_str(exp_path) : "";
      tests++;
      if (path_str(got_nodes) != exp_s || timed_out) begin
        fails++;
        $display("FAIL rand%0d_nodes got=%s exp=%s", it,
                 path_str(got_nodes), exp_s);
      end
      tests++;
      if (n_done != int'(exp_ok) || n_err != int'(!exp_ok)) begin
        fails++;
        $display("FAIL rand%0d_status got=%0d/%0d exp=%0d", it,
                 n_done, n_err, exp_ok);
      end
      tests++;
      if (path_len !== (exp_ok ? (W+1)'(exp_path.size()) : '0)) begin
        fails++;
        $display("FAIL rand%0d_len got=%0d exp=%0d", it, path_len,
                 exp_ok ? exp_path.size() : 0);
      end
      lat = exp_ok ? first_v : err_cyc;
      tests++;
      if (lat != 2 * exp_n + 2 || unstable != 0) begin
        fails++;
        $display("FAIL rand%0d_timing got=%0d exp=%0d unstable=%0d", it,
                 lat, 2 * exp_n + 2, unstable);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) pmem[i] = '0;
    test_reset();
    test_chain();
    test_same();
    test_self_loop();
    test_loop();
    test_stall();
    test_reset_emit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
